// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and
// baud-timing helpers used by both the receive and transmit halves.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } uart_rx_state_t;

    // Counter value at which the middle of the start bit is reached.
    function automatic int uart_half_bit(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic single-bit synchronizer chain for asynchronous input pins.
// The reset value lets idle-high lines (such as UART rxd) come out of reset
// without producing a false edge.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rxd, decodes 8N1 frames (LSB first) and
// presents each good byte as a single beat on a stream source with a
// one-entry output register. Framing errors and overruns are 1-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] tdata,
    output logic       tvalid,
    input  logic       tready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int             CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF       = CW'(uart_half_bit(CLKS_PER_BIT));
    localparam logic [CW-1:0]  LAST       = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_INDEX = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    uart_rx_state_t            state_r;
    uart_rx_state_t            next_state_s;
    logic [CW-1:0]             counter_r;
    logic [2:0]                index_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic                      counter_last_s;
    logic                      deliver_s;
    logic                      frame_err_s;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rx_s)
    );

    assign counter_last_s = (counter_r == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rx_s) next_state_s = START;
                else       next_state_s = IDLE;
            end
            START: begin
                if (counter_r == HALF) begin
                    // A start bit that is gone by mid-bit was a glitch.
                    if (!rx_s) next_state_s = DATA;
                    else       next_state_s = IDLE;
                end else begin
                    next_state_s = START;
                end
            end
            DATA: begin
                if (counter_last_s && (index_r == LAST_INDEX)) next_state_s = STOP;
                else                                           next_state_s = DATA;
            end
            STOP: begin
                // Leave at mid-stop-bit so the next start edge has no dead time.
                if (counter_last_s) begin
                    if (rx_s) next_state_s = IDLE;
                    else      next_state_s = BREAK_WAIT;
                end else begin
                    next_state_s = STOP;
                end
            end
            BREAK_WAIT: begin
                // A line held low must return high before a new frame can begin.
                if (rx_s) next_state_s = IDLE;
                else      next_state_s = BREAK_WAIT;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Frame-end decode: good byte or framing error at the mid-stop sample.
    always_comb begin
        deliver_s   = 1'b0;
        frame_err_s = 1'b0;
        if ((state_r == STOP) && counter_last_s) begin
            deliver_s   = rx_s;
            frame_err_s = !rx_s;
        end else begin
            deliver_s   = 1'b0;
            frame_err_s = 1'b0;
        end
    end

    // Bit-timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_r <= '0;
            index_r   <= 3'd0;
            shift_r   <= '0;
        end else begin
            case (state_r)
                START: begin
                    if (counter_r == HALF) counter_r <= '0;
                    else                   counter_r <= counter_r + CW'(1);
                end
                DATA: begin
                    if (counter_last_s) begin
                        counter_r <= '0;
                        shift_r   <= {rx_s, shift_r[UART_DATA_BITS-1:1]};
                        index_r   <= index_r + 3'd1;
                    end else begin
                        counter_r <= counter_r + CW'(1);
                    end
                end
                STOP: begin
                    if (counter_last_s) counter_r <= '0;
                    else                counter_r <= counter_r + CW'(1);
                end
                default: begin
                    counter_r <= '0;
                    index_r   <= 3'd0;
                end
            endcase
        end
    end

    // Single-entry output register and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata         <= 8'h00;
            tvalid        <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_err_s;
            overrun       <= deliver_s & tvalid & !tready;
            if (deliver_s && (!tvalid || tready)) begin
                tdata  <= shift_r;
                tvalid <= 1'b1;
            end else if (tvalid && tready) begin
                tvalid <= 1'b0;
            end else begin
                // Holding the beat keeps tdata stable while the sink stalls.
                tdata  <= tdata;
                tvalid <= tvalid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives rxd from a bit-accurate 8N1 frame model, keeps
// expected bytes and pulse counts in a scoreboard, and checks beats in a
// separate monitor process.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       tready = 1'b0;
    logic [7:0] tdata;
    logic       tvalid;
    logic       framing_error;
    logic       overrun;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int fe_cnt = 0;
    int ovr_cnt = 0;
    int exp_fe = 0;
    int exp_ovr = 0;
    bit rand_ready = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .tdata         (tdata),
        .tvalid        (tvalid),
        .tready        (tready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on each beat, checks hold rules and pulses.
    logic [7:0] held_data;
    bit held = 1'b0;
    bit fe_prev = 1'b0;
    bit ovr_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
            fe_prev = 1'b0;
            ovr_prev = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", int'(tvalid), 1);
                check("hold_data", int'(tdata), int'(held_data));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) check("beat_expected", int'(exp_q.size() > 0), 1);
                else                   check("beat_data", int'(tdata), int'(exp_q.pop_front()));
            end
            held = tvalid && !tready;
            held_data = tdata;
            if (framing_error) begin
                fe_cnt++;
                check("fe_width", int'(fe_prev), 0);
                check("fe_ovr_exclusive", int'(overrun), 0);
            end
            if (overrun) begin
                ovr_cnt++;
                check("ovr_width", int'(ovr_prev), 0);
            end
            fe_prev = framing_error;
            ovr_prev = overrun;
        end
    end

    // Random sink back-pressure when enabled.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            tready = 1'($urandom_range(0, 1));
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic send_byte(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_fe_count"}, fe_cnt, exp_fe);
        check({tag, "_ovr_count"}, ovr_cnt, exp_ovr);
    endtask

    initial begin
        logic [7:0] d;
        int hold;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", int'(tvalid), 0);
        check("rst_tdata", int'(tdata), 0);
        check("rst_fe", int'(framing_error), 0);
        check("rst_ovr", int'(overrun), 0);
        rst_n = 1'b1;
        idle_cycles(5);

        // 1: single byte with the sink always ready
        tready = 1'b1;
        send_byte(8'hA5);
        idle_cycles(20);
        wait_drain("t1_drain");
        check_pulses("t1");

        // 2: short low glitch is ignored, then a real byte
        rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle_cycles(30);
        check("t2_no_beat", int'(tvalid), 0);
        send_byte(8'h3C);
        idle_cycles(20);
        wait_drain("t2_drain");
        check_pulses("t2");

        // 3: bad stop bit with line held low, then recovery
        send_frame(8'h3C, 1'b0);
        exp_fe++;
        rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle_cycles(10);
        send_byte(8'h81);
        idle_cycles(20);
        wait_drain("t3_drain");
        check_pulses("t3");

        // 4: stalled sink, second byte overruns
        tready = 1'b0;
        send_byte(8'h11);
        send_frame(8'h22, 1'b1);
        exp_ovr++;
        idle_cycles(20);
        check("t4_tvalid", int'(tvalid), 1);
        check("t4_tdata", int'(tdata), 8'h11);
        check_pulses("t4");
        tready = 1'b1;
        @(posedge clk);
        #1;
        tready = 1'b0;
        check("t4_tvalid_after", int'(tvalid), 0);
        check("t4_queue", exp_q.size(), 0);

        // 5: accept of the old beat coincides with completion of the new byte
        send_byte(8'h5A);
        idle_cycles(10);
        fork
            send_byte(8'hE7);
            begin
                repeat (154) @(posedge clk);
                #1;
                tready = 1'b1;
                @(posedge clk);
                #1;
                tready = 1'b0;
            end
        join
        check("t5_tvalid", int'(tvalid), 1);
        check("t5_tdata", int'(tdata), 8'hE7);
        check("t5_queue", exp_q.size(), 1);
        check_pulses("t5");
        tready = 1'b1;
        idle_cycles(3);
        wait_drain("t5_drain");

        // 6: back-to-back frames with no idle gap
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h55);
        idle_cycles(20);
        wait_drain("t6_drain");
        check_pulses("t6");

        // Randomized frames, gaps, stop-bit errors and back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            idle_cycles($urandom_range(0, 20));
            if ($urandom_range(0, 5) == 0) begin
                send_frame(d, 1'b0);
                exp_fe++;
                hold = $urandom_range(0, 30);
                rxd = 1'b0;
                repeat (hold) @(posedge clk);
                #1;
                idle_cycles(2 + $urandom_range(0, 5));
            end else begin
                send_byte(d);
            end
        end
        idle_cycles(40);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        tready = 1'b1;
        wait_drain("rand_drain");
        check_pulses("rand");

        // Reset in the middle of a data bit abandons the frame and the beat
        tready = 1'b0;
        send_byte(8'h99);
        idle_cycles(5);
        check("rst_pre_tvalid", int'(tvalid), 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tvalid", int'(tvalid), 0);
        check("rst_mid_tdata", int'(tdata), 0);
        exp_q.delete();
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(5);
        tready = 1'b1;
        send_byte(8'hC3);
        idle_cycles(20);
        wait_drain("rst_drain");
        check_pulses("rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
